modulo_05: RTL
==============

Name: modulo_05

Overview:
- Display stage directly downstream of the SECDED correction stage (8-bit switch word, Hamming(7,4) plus global parity).
- Consumes the corrected nibble with its double-error flag, and the error position.
- Drives a 2-digit multiplexed 7-segment display and two status LEDs.
- Inputs are latched once per refresh frame so the display never tears, and digit changes are separated by blanking gaps to prevent ghosting.

Parameters:
- CLK_HZ, 27000000: system clock frequency.
- REFRESH_HZ, 1000: frame rate. Slot length DIV = CLK_HZ/(2*REFRESH_HZ) cycles per digit.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off. Elaboration error unless DIV > BLANK_CYC.
- BLINK_HZ, 2: blink rate on double error. Half-period BDIV = CLK_HZ/(2*BLINK_HZ) cycles.
- ACTIVO_BAJO, 1: 1 = anodes and segments active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- w_corregida_b4  in  5  [3:0] corrected data nibble; [4] double-error flag (data not trustworthy).
- pos_error  in  4  0 = no error; 1..7 = corrected bit position; 8 = global parity bit error.
- anodo  out  2  digit enables; [0] = digit 0 (data), [1] = digit 1 (position).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- led_corr  out  1  single error corrected (latched pos_error != 0 and no double error).
- led_doble  out  1  double error detected (latched).

Behaviour:
- All outputs are registered. Define OFF = all-ones if ACTIVO_BAJO else all-zeros, and ON = its complement.
- Reset (sampled on a clk edge with rst=1):
  - state = S_BLANK0, slot counter = 0, blink counter = 0, blink = 0.
  - Shadow registers = 0.
  - anodo = OFF, seg = OFF, led_corr = 0, led_doble = 0.
- Capture rule:
  - The cycle after rst deasserts, and every cycle the FSM enters S_BLANK0, the block captures w_corregida_b4 and pos_error into the shadow registers.
  - Mid-frame input changes are ignored until the next frame.
  - LEDs update from the shadow registers one cycle after capture.
- FSM with 4 states, each slot DIV cycles:
  - S_BLANK0 (BLANK_CYC cycles) -> S_DIG0 (DIV-BLANK_CYC cycles) -> S_BLANK1 (BLANK_CYC) -> S_DIG1 (DIV-BLANK_CYC) -> S_BLANK0.
  - Frame = 2*DIV cycles. The slot counter clears on every state change.
  - BLANK states: anodo = OFF, seg = OFF.
  - S_DIG0: anodo[0] = ON, others OFF; seg = hex glyph of shadow nibble.
  - S_DIG1: anodo[1] = ON; seg = hex glyph of shadow pos_error.
  - seg and anodo change on the same edge; both lag the state register by 0 cycles (decoded from next state).
- Hex table, active-high gfedcba (invert when ACTIVO_BAJO):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Double error (shadow [4]=1):
  - Both digits show 'E' (79) while blink=1, and seg = OFF while blink=0.
  - The anodo sequence is unchanged.
  - led_doble = 1, led_corr = 0.
- Blink counter:
  - Free-running; wraps at BDIV-1 and toggles blink on wrap.
  - Runs regardless of error state.
  - Blink phase is not reset by capture.
- pos_error values 9..15: displayed as their hex glyph, and led_corr = 1.
- Reset asserted mid-frame returns to the reset values on that edge; no partial slot completes.

Test Plan:
Sim parameters: CLK_HZ=1000, REFRESH_HZ=50 (DIV=10), BLANK_CYC=2, BLINK_HZ=25 (BDIV=20), ACTIVO_BAJO=1.
- Reset then release, w_corregida_b4=5'b01011, pos_error=6 -> cycles 0-1 anodo=11, seg=1111111; cycles 2-9 anodo=10, seg=0000011 ('b'); cycles 10-11 blank; cycles 12-19 anodo=01, seg=0000010 ('6'); led_corr=1, led_doble=0.
- Inputs changed at cycle 5 to 5'b00000/pos 0 -> digit 0 stays 'b' and digit 1 stays '6' through cycle 19; at cycle 20 capture, digit 0 shows '0' (1000000), led_corr=0 from cycle 21.
- pos_error=8, nibble 4'hD -> digits show 'd' (0100001) and '8' (0000000), led_corr=1.
- w_corregida_b4[4]=1 -> led_doble=1, led_corr=0; during DIG slots seg=0000110 ('E') for 20 cycles, then 1111111 for 20 cycles, repeating; anodo sequence unchanged.
- rst pulsed 1 cycle while in S_DIG1 -> next edge anodo=11, seg=1111111, LEDs 0; new frame restarts with capture on the release cycle.
- Sweep nibble 0..F, one per frame -> digit-0 glyph matches the hex table (inverted) for all 16 values.

Source files
------------

// File: rtl/modulo_05.sv
// modulo_05: two-digit multiplexed 7-segment display for the SECDED stage.
// It latches its inputs once per frame and blanks the display between digits.
module modulo_05 #(
    parameter int CLK_HZ      = 27000000,
    parameter int REFRESH_HZ  = 1000,
    parameter int BLANK_CYC   = 16,
    parameter int BLINK_HZ    = 2,
    parameter bit ACTIVO_BAJO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] w_corregida_b4,
    input  logic [3:0] pos_error,
    output logic [1:0] anodo,
    output logic [6:0] seg,
    output logic       led_corr,
    output logic       led_doble
);
    localparam int DIV  = CLK_HZ / (2 * REFRESH_HZ);
    localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = $clog2(DIV + 1);
    localparam int BW   = $clog2(BDIV + 1);

    if (DIV <= BLANK_CYC) begin : g_chk
        $error("modulo_05: DIV must be greater than BLANK_CYC");
    end

    typedef enum logic [1:0] {S_BLANK0, S_DIG0, S_BLANK1, S_DIG1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          blink, blink_n, wrap, last, fresh, capture;
    logic [4:0]    sh_w, sh_w_n;
    logic [3:0]    sh_p, sh_p_n, digit;
    logic [6:0]    seg_hi;
    logic [1:0]    an_hi;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        last    = cnt == ((state == S_BLANK0 || state == S_BLANK1) ? CW'(BLANK_CYC - 1)
                                                                   : CW'(DIV - BLANK_CYC - 1));
        state_n = last ? state_t'(state + 2'd1) : state;
        wrap    = bcnt == BW'(BDIV - 1);
        blink_n = blink ^ wrap;
        // fresh covers the first cycle after reset; otherwise capture on frame wrap
        capture = fresh || (state == S_DIG1 && last);
        sh_w_n  = capture ? w_corregida_b4 : sh_w;
        sh_p_n  = capture ? pos_error : sh_p;
        digit   = state_n == S_DIG0 ? sh_w_n[3:0] : sh_p_n;
        an_hi   = {state_n == S_DIG1, state_n == S_DIG0};
        seg_hi  = an_hi == 2'b00 ? 7'h00 : sh_w_n[4] ? (blink_n ? 7'h79 : 7'h00) : glyph(digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_BLANK0;
            cnt       <= '0;
            bcnt      <= '0;
            blink     <= 1'b0;
            fresh     <= 1'b1;
            sh_w      <= '0;
            sh_p      <= '0;
            anodo     <= {2{ACTIVO_BAJO}};
            seg       <= {7{ACTIVO_BAJO}};
            led_corr  <= 1'b0;
            led_doble <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= last ? '0 : cnt + 1'b1;
            bcnt      <= wrap ? '0 : bcnt + 1'b1;
            blink     <= blink_n;
            fresh     <= 1'b0;
            sh_w      <= sh_w_n;
            sh_p      <= sh_p_n;
            anodo     <= ACTIVO_BAJO ? ~an_hi : an_hi;
            seg       <= ACTIVO_BAJO ? ~seg_hi : seg_hi;
            led_corr  <= sh_p != 4'd0 && !sh_w[4];
            led_doble <= sh_w[4];
        end
    end
endmodule
